// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle control sequencer for the RV32 datapath: R-type, load, store, branch,
// with a mem_ready handshake timeout and a retired-instruction counter. Define ITYPE_EN to add I-type ALU ops.
module multicycle_ctrl_fsm #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [6:0]       opcode_i,
    input  logic             zero_i,
    input  logic             mem_ready_i,
    output logic             pc_write_o,
    output logic             pc_src_o,
    output logic             ir_write_o,
    output logic             iord_o,
    output logic             mem_read_o,
    output logic             mem_write_o,
    output logic             reg_write_o,
    output logic             memtoreg_o,
    output logic             alu_src_a_o,
    output logic [1:0]       alu_src_b_o,
    output logic [1:0]       alu_op_o,
    output logic             trap_o,
    output logic             trap_cause_o,
    output logic [CNT_W-1:0] instret_o
);
    localparam int unsigned WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
`ifdef ITYPE_EN
    localparam logic [6:0] OP_I      = 7'b0010011;
`endif

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_MEM_ADR, S_MEM_RD, S_MEM_WB,
        S_MEM_WR, S_EXEC_R, S_EXEC_I, S_ALU_WB, S_BRANCH, S_TRAP
    } state_e;

    state_e             state_q, state_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]   instret_q, instret_d;
    logic               trap_cause_q, trap_cause_d;
    logic               is_req, timeout, retire;

    logic               pc_src_q, pc_src_d;
    logic               iord_q, iord_d;
    logic               mem_read_q, mem_read_d;
    logic               mem_write_q, mem_write_d;
    logic               reg_write_q, reg_write_d;
    logic               memtoreg_q, memtoreg_d;
    logic               alu_src_a_q, alu_src_a_d;
    logic [1:0]         alu_src_b_q, alu_src_b_d;
    logic [1:0]         alu_op_q, alu_op_d;
    logic               trap_q, trap_d;

    // Next state, wait counter, retire, and the select/enable set for the next state.
    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = '0;
        instret_d    = instret_q;
        trap_cause_d = trap_cause_q;
        retire       = 1'b0;
        is_req       = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
        timeout      = !mem_ready_i && (wait_cnt_q == WAIT_W'(MEM_TIMEOUT - 1));

        if (is_req && !mem_ready_i) begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end

        case (state_q)
            S_IDLE:    state_d = S_FETCH;
            S_FETCH: begin
                if (mem_ready_i) begin
                    state_d = S_DECODE;
                end else if (timeout) begin
                    state_d      = S_TRAP;
                    trap_cause_d = 1'b1;
                end
            end
            S_DECODE: begin
                case (opcode_i)
                    OP_R:               state_d = S_EXEC_R;
                    OP_LOAD, OP_STORE:  state_d = S_MEM_ADR;
                    OP_BRANCH:          state_d = S_BRANCH;
`ifdef ITYPE_EN
                    OP_I:               state_d = S_EXEC_I;
`endif
                    default: begin
                        state_d      = S_TRAP;
                        trap_cause_d = 1'b0;
                    end
                endcase
            end
            S_MEM_ADR: state_d = (opcode_i == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: begin
                if (mem_ready_i) begin
                    state_d = S_MEM_WB;
                end else if (timeout) begin
                    state_d      = S_TRAP;
                    trap_cause_d = 1'b1;
                end
            end
            S_MEM_WB: begin
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_MEM_WR: begin
                if (mem_ready_i) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else if (timeout) begin
                    state_d      = S_TRAP;
                    trap_cause_d = 1'b1;
                end
            end
            S_EXEC_R, S_EXEC_I: state_d = S_ALU_WB;
            S_ALU_WB, S_BRANCH: begin
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_TRAP:    state_d = S_TRAP;
            default:   state_d = S_IDLE;
        endcase

        if (retire) begin
            instret_d = instret_q + CNT_W'(1);
        end

        pc_src_d    = 1'b0;
        iord_d      = 1'b0;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        reg_write_d = 1'b0;
        memtoreg_d  = 1'b0;
        alu_src_a_d = 1'b0;
        alu_src_b_d = 2'b00;
        alu_op_d    = 2'b00;
        trap_d      = 1'b0;

        // Registering the decode of state_d keeps outputs aligned with state_q.
        case (state_d)
            S_FETCH: begin
                mem_read_d  = 1'b1;
                alu_src_b_d = 2'b01;
            end
            S_DECODE:  alu_src_b_d = 2'b10;
            S_MEM_ADR: begin
                alu_src_a_d = 1'b1;
                alu_src_b_d = 2'b10;
            end
            S_MEM_RD: begin
                mem_read_d = 1'b1;
                iord_d     = 1'b1;
            end
            S_MEM_WB: begin
                reg_write_d = 1'b1;
                memtoreg_d  = 1'b1;
            end
            S_MEM_WR: begin
                mem_write_d = 1'b1;
                iord_d      = 1'b1;
            end
            S_EXEC_R: begin
                alu_src_a_d = 1'b1;
                alu_op_d    = 2'b10;
            end
            S_EXEC_I: begin
                alu_src_a_d = 1'b1;
                alu_src_b_d = 2'b10;
                alu_op_d    = 2'b10;
            end
            S_ALU_WB:  reg_write_d = 1'b1;
            S_BRANCH: begin
                alu_src_a_d = 1'b1;
                alu_op_d    = 2'b01;
                pc_src_d    = 1'b1;
            end
            S_TRAP:    trap_d = 1'b1;
            default:   ;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= S_IDLE;
            wait_cnt_q   <= '0;
            instret_q    <= '0;
            trap_cause_q <= 1'b0;
            pc_src_q     <= 1'b0;
            iord_q       <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            reg_write_q  <= 1'b0;
            memtoreg_q   <= 1'b0;
            alu_src_a_q  <= 1'b0;
            alu_src_b_q  <= 2'b00;
            alu_op_q     <= 2'b00;
            trap_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            instret_q    <= instret_d;
            trap_cause_q <= trap_cause_d;
            pc_src_q     <= pc_src_d;
            iord_q       <= iord_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            reg_write_q  <= reg_write_d;
            memtoreg_q   <= memtoreg_d;
            alu_src_a_q  <= alu_src_a_d;
            alu_src_b_q  <= alu_src_b_d;
            alu_op_q     <= alu_op_d;
            trap_q       <= trap_d;
        end
    end

    // Handshake- and flag-gated enables follow the live inputs within the cycle.
    assign ir_write_o   = (state_q == S_FETCH) && mem_ready_i;
    assign pc_write_o   = ir_write_o || ((state_q == S_BRANCH) && zero_i);

    assign pc_src_o     = pc_src_q;
    assign iord_o       = iord_q;
    assign mem_read_o   = mem_read_q;
    assign mem_write_o  = mem_write_q;
    assign reg_write_o  = reg_write_q;
    assign memtoreg_o   = memtoreg_q;
    assign alu_src_a_o  = alu_src_a_q;
    assign alu_src_b_o  = alu_src_b_q;
    assign alu_op_o     = alu_op_q;
    assign trap_o       = trap_q;
    assign trap_cause_o = trap_cause_q;
    assign instret_o    = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Scoreboard bench for multicycle_ctrl_fsm: stimulus queues the expected control word
// and instret for each cycle; a negedge monitor pops and compares.
module tb_multicycle_ctrl_fsm;
    localparam int unsigned CNT_W = 4;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BAD    = 7'b1111111;

    // {pc_write, pc_src, ir_write, iord, mem_read, mem_write, reg_write, memtoreg, alu_src_a, alu_src_b, alu_op, trap, trap_cause}
    localparam logic [14:0] C_IDLE   = 15'b0_0_0_0_0_0_0_0_0_00_00_0_0;
    localparam logic [14:0] C_FETCHW = 15'b0_0_0_0_1_0_0_0_0_01_00_0_0;
    localparam logic [14:0] C_FETCH  = 15'b1_0_1_0_1_0_0_0_0_01_00_0_0;
    localparam logic [14:0] C_DECODE = 15'b0_0_0_0_0_0_0_0_0_10_00_0_0;
    localparam logic [14:0] C_MEMADR = 15'b0_0_0_0_0_0_0_0_1_10_00_0_0;
    localparam logic [14:0] C_MEMRD  = 15'b0_0_0_1_1_0_0_0_0_00_00_0_0;
    localparam logic [14:0] C_MEMWB  = 15'b0_0_0_0_0_0_1_1_0_00_00_0_0;
    localparam logic [14:0] C_MEMWR  = 15'b0_0_0_1_0_1_0_0_0_00_00_0_0;
    localparam logic [14:0] C_EXECR  = 15'b0_0_0_0_0_0_0_0_1_00_10_0_0;
    localparam logic [14:0] C_EXECI  = 15'b0_0_0_0_0_0_0_0_1_10_10_0_0;
    localparam logic [14:0] C_ALUWB  = 15'b0_0_0_0_0_0_1_0_0_00_00_0_0;
    localparam logic [14:0] C_BRT    = 15'b1_1_0_0_0_0_0_0_1_00_01_0_0;
    localparam logic [14:0] C_BRN    = 15'b0_1_0_0_0_0_0_0_1_00_01_0_0;
    localparam logic [14:0] C_TRAP0  = 15'b0_0_0_0_0_0_0_0_0_00_00_1_0;
    localparam logic [14:0] C_TRAP1  = 15'b0_0_0_0_0_0_0_0_0_00_00_1_1;

    typedef struct {
        logic [14:0]      ctrl;
        logic [CNT_W-1:0] instret;
        string            tag;
    } exp_t;

    logic             clk_i = 1'b0;
    logic             reset_i = 1'b1;
    logic [6:0]       opcode_i = OP_R;
    logic             zero_i = 1'b0;
    logic             mem_ready_i = 1'b0;
    logic             pc_write_o, pc_src_o, ir_write_o, iord_o, mem_read_o, mem_write_o;
    logic             reg_write_o, memtoreg_o, alu_src_a_o, trap_o, trap_cause_o;
    logic [1:0]       alu_src_b_o, alu_op_o;
    logic [CNT_W-1:0] instret_o;
    logic [14:0]      ctrl_act;

    exp_t             exp_q[$];
    exp_t             e_mon;
    logic [CNT_W-1:0] exp_instret = '0;
    int               tests = 0;
    int               failed = 0;

    multicycle_ctrl_fsm #(.MEM_TIMEOUT(16), .CNT_W(CNT_W)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .opcode_i(opcode_i), .zero_i(zero_i),
        .mem_ready_i(mem_ready_i), .pc_write_o(pc_write_o), .pc_src_o(pc_src_o),
        .ir_write_o(ir_write_o), .iord_o(iord_o), .mem_read_o(mem_read_o),
        .mem_write_o(mem_write_o), .reg_write_o(reg_write_o), .memtoreg_o(memtoreg_o),
        .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o), .alu_op_o(alu_op_o),
        .trap_o(trap_o), .trap_cause_o(trap_cause_o), .instret_o(instret_o)
    );

    always #5 clk_i = ~clk_i;

    assign ctrl_act = {pc_write_o, pc_src_o, ir_write_o, iord_o, mem_read_o, mem_write_o,
                       reg_write_o, memtoreg_o, alu_src_a_o, alu_src_b_o, alu_op_o,
                       trap_o, trap_cause_o};

    always @(negedge clk_i) begin
        if (exp_q.size() != 0) begin
            e_mon = exp_q.pop_front();
            tests++;
            if (ctrl_act !== e_mon.ctrl || instret_o !== e_mon.instret) begin
                failed++;
                $display("FAIL %s: got ctrl=%b instret=%0d, expected ctrl=%b instret=%0d",
                         e_mon.tag, ctrl_act, instret_o, e_mon.ctrl, e_mon.instret);
            end
        end
    end

    // Drive one cycle of inputs, queue its expected outputs, advance past the edge.
    task automatic step(input logic rst, input logic [6:0] op, input logic rdy, input logic z,
                        input logic [14:0] ctrl, input bit ret, input string tag);
        exp_t e;
        reset_i     = rst;
        opcode_i    = op;
        mem_ready_i = rdy;
        zero_i      = z;
        if (rst) exp_instret = '0;
        e.ctrl    = ctrl;
        e.instret = exp_instret;
        e.tag     = tag;
        exp_q.push_back(e);
        @(posedge clk_i);
        #1;
        if (ret && !rst) exp_instret = exp_instret + CNT_W'(1);
    endtask

    task automatic do_reset();
        step(1'b1, OP_R, 1'b1, 1'b0, C_IDLE, 1'b0, "reset");
        step(1'b0, OP_R, 1'b1, 1'b0, C_IDLE, 1'b0, "idle");
    endtask

    task automatic rtype();
        step(1'b0, OP_R, 1'b1, 1'b0, C_FETCH,  1'b0, "r_fetch");
        step(1'b0, OP_R, 1'b1, 1'b0, C_DECODE, 1'b0, "r_decode");
        step(1'b0, OP_R, 1'b1, 1'b0, C_EXECR,  1'b0, "r_exec");
        step(1'b0, OP_R, 1'b1, 1'b0, C_ALUWB,  1'b1, "r_wb");
    endtask

    task automatic branch(input logic z);
        step(1'b0, OP_BRANCH, 1'b1, z, C_FETCH,  1'b0, "br_fetch");
        step(1'b0, OP_BRANCH, 1'b1, z, C_DECODE, 1'b0, "br_decode");
        step(1'b0, OP_BRANCH, 1'b1, z, z ? C_BRT : C_BRN, 1'b1, z ? "br_taken" : "br_not_taken");
    endtask

    initial begin
        @(posedge clk_i);
        #1;
        do_reset();

        rtype();

        // Load with three wait cycles in MEM_RD: 8 cycles total
        step(1'b0, OP_LOAD, 1'b1, 1'b0, C_FETCH,  1'b0, "ld_fetch");
        step(1'b0, OP_LOAD, 1'b1, 1'b0, C_DECODE, 1'b0, "ld_decode");
        step(1'b0, OP_LOAD, 1'b1, 1'b0, C_MEMADR, 1'b0, "ld_memadr");
        for (int i = 0; i < 3; i++) step(1'b0, OP_LOAD, 1'b0, 1'b0, C_MEMRD, 1'b0, "ld_memrd_wait");
        step(1'b0, OP_LOAD, 1'b1, 1'b0, C_MEMRD, 1'b0, "ld_memrd_done");
        step(1'b0, OP_LOAD, 1'b1, 1'b0, C_MEMWB, 1'b1, "ld_memwb");

        branch(1'b1);
        branch(1'b0);

        step(1'b0, OP_STORE, 1'b1, 1'b0, C_FETCH,  1'b0, "st_fetch");
        step(1'b0, OP_STORE, 1'b1, 1'b0, C_DECODE, 1'b0, "st_decode");
        step(1'b0, OP_STORE, 1'b1, 1'b0, C_MEMADR, 1'b0, "st_memadr");
        step(1'b0, OP_STORE, 1'b0, 1'b0, C_MEMWR,  1'b0, "st_memwr_wait");
        step(1'b0, OP_STORE, 1'b1, 1'b0, C_MEMWR,  1'b1, "st_memwr_done");

        // Bring instret to 2^CNT_W-1, then one more retire wraps it to 0
        for (int i = 0; i < 10; i++) rtype();
        branch(1'b0);
        rtype();

        // Reset during a pending store write: outputs drop before the next edge
        step(1'b0, OP_STORE, 1'b1, 1'b0, C_FETCH,  1'b0, "st2_fetch");
        step(1'b0, OP_STORE, 1'b1, 1'b0, C_DECODE, 1'b0, "st2_decode");
        step(1'b0, OP_STORE, 1'b1, 1'b0, C_MEMADR, 1'b0, "st2_memadr");
        step(1'b0, OP_STORE, 1'b0, 1'b0, C_MEMWR,  1'b0, "st2_memwr_wait");
        step(1'b1, OP_STORE, 1'b1, 1'b0, C_IDLE,   1'b0, "reset_in_memwr");
        step(1'b0, OP_R,     1'b1, 1'b0, C_IDLE,   1'b0, "idle_after_abort");
        rtype();

        // FETCH timeout after 16 request cycles, then TRAP holds
        do_reset();
        for (int i = 0; i < 16; i++) step(1'b0, OP_R, 1'b0, 1'b0, C_FETCHW, 1'b0, "to_fetch_wait");
        for (int i = 0; i < 3; i++) step(1'b0, OP_R, 1'b1, 1'b1, C_TRAP1, 1'b0, "to_trap_hold");

        // Handshake on the 16th request cycle beats the timeout
        do_reset();
        for (int i = 0; i < 15; i++) step(1'b0, OP_R, 1'b0, 1'b0, C_FETCHW, 1'b0, "nto_fetch_wait");
        step(1'b0, OP_R, 1'b1, 1'b0, C_FETCH,  1'b0, "nto_fetch_done");
        step(1'b0, OP_R, 1'b1, 1'b0, C_DECODE, 1'b0, "nto_decode");
        step(1'b0, OP_R, 1'b1, 1'b0, C_EXECR,  1'b0, "nto_exec");
        step(1'b0, OP_R, 1'b1, 1'b0, C_ALUWB,  1'b1, "nto_wb");
        step(1'b0, OP_R, 1'b1, 1'b0, C_FETCH,  1'b0, "nto_next_fetch");

        // Illegal opcode
        do_reset();
        step(1'b0, OP_BAD, 1'b1, 1'b0, C_FETCH,  1'b0, "bad_fetch");
        step(1'b0, OP_BAD, 1'b1, 1'b0, C_DECODE, 1'b0, "bad_decode");
        step(1'b0, OP_R,   1'b1, 1'b0, C_TRAP0,  1'b0, "bad_trap");
        step(1'b0, OP_R,   1'b0, 1'b1, C_TRAP0,  1'b0, "bad_trap_hold");

        // I-type opcode
        do_reset();
        step(1'b0, OP_I, 1'b1, 1'b0, C_FETCH,  1'b0, "i_fetch");
        step(1'b0, OP_I, 1'b1, 1'b0, C_DECODE, 1'b0, "i_decode");
`ifdef ITYPE_EN
        step(1'b0, OP_I, 1'b1, 1'b0, C_EXECI,  1'b0, "i_exec");
        step(1'b0, OP_I, 1'b1, 1'b0, C_ALUWB,  1'b1, "i_wb");
        step(1'b0, OP_I, 1'b1, 1'b0, C_FETCH,  1'b0, "i_next_fetch");
`else
        step(1'b0, OP_I, 1'b1, 1'b0, C_TRAP0,  1'b0, "i_illegal_trap");
        step(1'b0, OP_I, 1'b1, 1'b0, C_TRAP0,  1'b0, "i_illegal_hold");
`endif

        tests++;
        if (exp_q.size() != 0) begin
            failed++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
